mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage RV32 core, directly downstream of the EX/MEM pipeline register.
//  Turns EX/MEM load/store controls into a single-outstanding data-memory request (req/ready + rvalid).
//  Generates D_core_wait to freeze the upstream stages. Aligns store data/strobes and sign/zero-extends load data.
//  Contains the MEM/WB pipeline register.
// PARAMETERS
//  XLEN     32  data width (fixed 32 for RV32; widths below assume 32)
//  ADDR_W   32  data-memory address width
// PORTS
//  clk                input   1      core clock, all state on rising edge
//  rst                input   1      asynchronous, active-high reset
//  EX_MEM_MemRead     input   1      load in MEM stage
//  EX_MEM_MemWrite    input   1      store in MEM stage
//  EX_MEM_RegWrite    input   1      instruction writes rd
//  EX_MEM_MemtoReg    input   1      1: WB selects load data
//  EX_MEM_funct3      input   3      LB/LH/LW/LBU/LHU, SB/SH/SW encoding
//  EX_MEM_ALU_result  input   32     effective address / ALU result
//  EX_MEM_RS2_Data    input   32     raw store data
//  EX_MEM_Rd          input   5      destination register
//  D_req              output  1      request valid, held until D_ready
//  D_we               output  1      1 store, 0 load
//  D_addr             output  ADDR_W word-aligned address ({addr[31:2],2'b00})
//  D_wstrb            output  4      byte strobes (loads: 4'b0000)
//  D_wdata            output  32     lane-aligned store data
//  D_ready            input   1      memory accepts request this cycle
//  D_rvalid           input   1      load data valid (one cycle)
//  D_rdata            input   32     raw load word
//  D_core_wait        output  1      stall EX/MEM and upstream stages
//  misalign           output  1      1-cycle pulse: misaligned access dropped
//  MEM_WB_RegWrite    output  1      registered
//  MEM_WB_MemtoReg    output  1      registered
//  MEM_WB_Rd          output  5      registered
//  MEM_WB_ALU_result  output  32     registered
//  MEM_WB_load_data   output  32     registered, extended load value
// BEHAVIOUR
//  FSM states: IDLE, REQ, RESP, DONE; reset -> IDLE.
//  - IDLE: aligned MemRead|MemWrite -> REQ. D_core_wait = 1 in this same cycle (combinational).
//  - REQ: D_req=1, outputs stable. D_ready & store -> DONE. D_ready & load -> RESP. Else stay in REQ.
//  - RESP: D_req=0. D_rvalid -> DONE; rdata captured into an internal register this cycle.
//  - DONE: D_core_wait=0 for exactly 1 cycle; MEM/WB loads the result; next state IDLE.
//  D_core_wait = (IDLE & access & aligned) | REQ | RESP; 0 in DONE and for non-memory instructions.
//  Memory latency:
//  - Store, zero wait states: 3 cycles (IDLE, REQ, DONE).
//  - Load, D_rvalid the cycle after acceptance: 4 cycles.
//  Misalignment:
//  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
//  - No request issued, no stall; misalign=1 that cycle.
//  - MEM_WB_RegWrite <= 0 for that instruction.
//  Store lanes, off = addr[1:0]:
//  - SB: wstrb = 4'b0001<<off, wdata = {4{rs2[7:0]}}.
//  - SH: wstrb = 4'b0011<<off, wdata = {2{rs2[15:0]}}.
//  - SW: wstrb = 4'b1111, wdata = rs2.
//  Loads:
//  - Byte/half selected by off.
//  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//  MEM/WB register:
//  - Loads the EX/MEM fields + extended load data when D_core_wait=0.
//  - While D_core_wait=1: MEM_WB_RegWrite <= 0 (bubble), other fields hold.
//  Reset values:
//  - D_req=0, D_we=0, D_addr=0, D_wstrb=0, D_wdata=0, misalign=0.
//  - All MEM_WB_* = 0. Register file sees no write.
//  Boundary cases:
//  - rst mid-transaction: FSM -> IDLE immediately, D_req drops, pending rvalid ignored.
//  - D_rvalid in IDLE/REQ/DONE: ignored.
//  - D_ready while in RESP: ignored.
//  - Back-to-back memory instructions: DONE -> IDLE -> REQ, no lost or duplicated access.
//  - Each access issues exactly one accepted request.
// TESTING
//  1) Reset asserted, then released:
//     - D_req=0, D_core_wait=0, MEM_WB_RegWrite=0.
//  2) SB, addr=0x1003, rs2=0xAABBCCDD, D_ready tied 1:
//     - D_wstrb=4'b1000, D_wdata=0xDDDDDDDD, D_addr=0x1000.
//     - D_core_wait high 2 cycles.
//  3) LB, addr=0x2002, D_rdata=0x00800000, rvalid 3 cycles after accept:
//     - MEM_WB_load_data=0xFFFFFF80. LBU gives 0x00000080.
//  4) LW, D_ready held low 5 cycles:
//     - D_req and D_addr stable throughout.
//     - D_core_wait stays 1; MEM_WB_RegWrite=0 during the stall.
//  5) LH, addr=0x3001:
//     - misalign pulse, no D_req, no stall, MEM_WB_RegWrite=0.
//  6) rst pulsed while in RESP, then a late D_rvalid arrives:
//     - FSM back to IDLE, D_rvalid ignored, no write-back.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32 MEM stage: data-memory handshake, lane alignment, MEM/WB register
module mem_access_stage #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_MEM_MemRead,
    input  logic              EX_MEM_MemWrite,
    input  logic              EX_MEM_RegWrite,
    input  logic              EX_MEM_MemtoReg,
    input  logic [2:0]        EX_MEM_funct3,
    input  logic [XLEN-1:0]   EX_MEM_ALU_result,
    input  logic [XLEN-1:0]   EX_MEM_RS2_Data,
    input  logic [4:0]        EX_MEM_Rd,
    output logic              D_req,
    output logic              D_we,
    output logic [ADDR_W-1:0] D_addr,
    output logic [3:0]        D_wstrb,
    output logic [XLEN-1:0]   D_wdata,
    input  logic              D_ready,
    input  logic              D_rvalid,
    input  logic [XLEN-1:0]   D_rdata,
    output logic              D_core_wait,
    output logic              misalign,
    output logic              MEM_WB_RegWrite,
    output logic              MEM_WB_MemtoReg,
    output logic [4:0]        MEM_WB_Rd,
    output logic [XLEN-1:0]   MEM_WB_ALU_result,
    output logic [XLEN-1:0]   MEM_WB_load_data
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_rdata;
    logic              w_access;
    logic              w_misaligned;
    logic              w_start;
    logic [1:0]        w_off;
    logic [3:0]        w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load_data;

    // funct3[1:0] encodes access size: 00 byte, 01 half, otherwise word
    always_comb begin
        w_access     = EX_MEM_MemRead | EX_MEM_MemWrite;
        w_off        = EX_MEM_ALU_result[1:0];
        w_misaligned = ((EX_MEM_funct3[1:0] == 2'b01) && w_off[0]) ||
                       (EX_MEM_funct3[1] && (w_off != 2'b00));
        w_start      = (r_state == S_IDLE) && w_access && !w_misaligned;
    end

    always_comb begin
        w_next_state = r_state;
        D_req        = 1'b0;
        D_core_wait  = 1'b0;
        misalign     = 1'b0;
        case (r_state)
            S_IDLE: begin
                misalign    = w_access && w_misaligned;
                D_core_wait = w_start;
                if (w_start) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                D_req       = 1'b1;
                D_core_wait = 1'b1;
                if (D_ready) begin
                    w_next_state = D_we ? S_DONE : S_RESP;
                end
            end
            S_RESP: begin
                D_core_wait = 1'b1;
                if (D_rvalid) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = EX_MEM_RS2_Data;
        case (EX_MEM_funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << w_off;
                w_wdata = {4{EX_MEM_RS2_Data[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << w_off;
                w_wdata = {2{EX_MEM_RS2_Data[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = EX_MEM_RS2_Data;
            end
        endcase
    end

    // Extension uses the still-held EX/MEM funct3/offset; they stay stable until DONE
    always_comb begin
        w_byte = r_rdata[{w_off, 3'b000} +: 8];
        w_half = w_off[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (EX_MEM_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = r_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_rdata           <= '0;
            D_we              <= 1'b0;
            D_addr            <= '0;
            D_wstrb           <= 4'b0000;
            D_wdata           <= '0;
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_MemtoReg   <= 1'b0;
            MEM_WB_Rd         <= 5'd0;
            MEM_WB_ALU_result <= '0;
            MEM_WB_load_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                D_we    <= EX_MEM_MemWrite;
                D_addr  <= {EX_MEM_ALU_result[ADDR_W-1:2], 2'b00};
                D_wstrb <= EX_MEM_MemWrite ? w_wstrb : 4'b0000;
                D_wdata <= EX_MEM_MemWrite ? w_wdata : '0;
            end
            if ((r_state == S_RESP) && D_rvalid) begin
                r_rdata <= D_rdata;
            end
            if (D_core_wait) begin
                MEM_WB_RegWrite <= 1'b0;
            end else begin
                MEM_WB_RegWrite   <= EX_MEM_RegWrite && !misalign;
                MEM_WB_MemtoReg   <= EX_MEM_MemtoReg;
                MEM_WB_Rd         <= EX_MEM_Rd;
                MEM_WB_ALU_result <= EX_MEM_ALU_result;
                MEM_WB_load_data  <= w_load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        EX_MEM_MemRead = 1'b0, EX_MEM_MemWrite = 1'b0, EX_MEM_RegWrite = 1'b0, EX_MEM_MemtoReg = 1'b0;
    logic [2:0]  EX_MEM_funct3 = 3'd0;
    logic [31:0] EX_MEM_ALU_result = 32'd0, EX_MEM_RS2_Data = 32'd0;
    logic [4:0]  EX_MEM_Rd = 5'd0;
    logic        D_req, D_we, D_core_wait, misalign;
    logic [31:0] D_addr, D_wdata;
    logic [3:0]  D_wstrb;
    logic        D_ready = 1'b0, D_rvalid = 1'b0;
    logic [31:0] D_rdata = 32'd0;
    logic        MEM_WB_RegWrite, MEM_WB_MemtoReg;
    logic [4:0]  MEM_WB_Rd;
    logic [31:0] MEM_WB_ALU_result, MEM_WB_load_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] load_data;
        logic [4:0]  rd;
        int          wait_cycles;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] obs_addr, obs_wdata, obs_wb_alu, obs_wb_load;
    logic [3:0]  obs_wstrb;
    logic [4:0]  obs_wb_rd;
    logic        obs_we, obs_stable, obs_bubble_ok, obs_timeout, obs_wb_rw, obs_wb_m2r;
    int          obs_req_cnt, obs_wait;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemtoReg(EX_MEM_MemtoReg),
        .EX_MEM_funct3(EX_MEM_funct3), .EX_MEM_ALU_result(EX_MEM_ALU_result),
        .EX_MEM_RS2_Data(EX_MEM_RS2_Data), .EX_MEM_Rd(EX_MEM_Rd),
        .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wstrb(D_wstrb), .D_wdata(D_wdata),
        .D_ready(D_ready), .D_rvalid(D_rvalid), .D_rdata(D_rdata),
        .D_core_wait(D_core_wait), .misalign(misalign),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_MemtoReg(MEM_WB_MemtoReg), .MEM_WB_Rd(MEM_WB_Rd),
        .MEM_WB_ALU_result(MEM_WB_ALU_result), .MEM_WB_load_data(MEM_WB_load_data)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic mr, input logic mw, input logic rw, input logic m2r,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [4:0] rd);
        EX_MEM_MemRead = mr; EX_MEM_MemWrite = mw; EX_MEM_RegWrite = rw; EX_MEM_MemtoReg = m2r;
        EX_MEM_funct3 = f3; EX_MEM_ALU_result = addr; EX_MEM_RS2_Data = rs2; EX_MEM_Rd = rd;
    endtask

    // Plays the memory side for one instruction; junk adds stray rvalid in REQ and stray ready in RESP
    task automatic do_access(input int ready_lat, input int rv_lat, input logic [31:0] rdata, input logic junk);
        int cyc = 0;
        int req_seen = 0;
        int rv_left = 0;
        logic fin = 1'b0;
        obs_req_cnt = 0; obs_wait = 0; obs_stable = 1'b1; obs_bubble_ok = 1'b1; obs_timeout = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (D_core_wait) begin
                obs_wait++;
                if (cyc > 0 && MEM_WB_RegWrite !== 1'b0) obs_bubble_ok = 1'b0;
            end else begin
                fin = 1'b1;
            end
            if (rv_left > 0) begin
                rv_left--;
                if (rv_left == 0) begin D_rvalid = 1'b1; D_rdata = rdata; end
                else if (junk) D_ready = 1'b1;
            end
            if (D_req === 1'b1) begin
                if (req_seen == 0) begin
                    obs_addr = D_addr; obs_we = D_we; obs_wstrb = D_wstrb; obs_wdata = D_wdata;
                end else if (D_addr !== obs_addr || D_we !== obs_we || D_wstrb !== obs_wstrb || D_wdata !== obs_wdata) begin
                    obs_stable = 1'b0;
                end
                if (req_seen >= ready_lat) begin
                    D_ready = 1'b1; obs_req_cnt++; rv_left = rv_lat;
                end else if (junk) begin
                    D_rvalid = 1'b1; D_rdata = ~rdata;
                end
                req_seen++;
            end
            @(posedge clk); #1;
            D_ready = 1'b0; D_rvalid = 1'b0;
            cyc++;
            if (cyc > 60) begin obs_timeout = 1'b1; fin = 1'b1; end
        end
        obs_wb_rw = MEM_WB_RegWrite; obs_wb_m2r = MEM_WB_MemtoReg; obs_wb_rd = MEM_WB_Rd;
        obs_wb_alu = MEM_WB_ALU_result; obs_wb_load = MEM_WB_load_data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (D_req !== 1'b0) begin errors++; $display("FAIL rst_held_d_req: got %b expected 0", D_req); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (D_req !== 1'b0) begin errors++; $display("FAIL reset_d_req: got %b expected 0", D_req); end
        checks++; if (D_core_wait !== 1'b0) begin errors++; $display("FAIL reset_core_wait: got %b expected 0", D_core_wait); end
        checks++; if (MEM_WB_RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b expected 0", MEM_WB_RegWrite); end
        checks++; if (D_addr !== 32'd0 || D_wstrb !== 4'd0 || D_wdata !== 32'd0 || D_we !== 1'b0) begin errors++; $display("FAIL reset_req_fields: got addr %h strb %b data %h we %b expected zeros", D_addr, D_wstrb, D_wdata, D_we); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
        checks++; if (MEM_WB_Rd !== 5'd0 || MEM_WB_ALU_result !== 32'd0 || MEM_WB_load_data !== 32'd0) begin errors++; $display("FAIL reset_mem_wb: got rd %0d alu %h ld %h expected zeros", MEM_WB_Rd, MEM_WB_ALU_result, MEM_WB_load_data); end
        @(posedge clk); #1;
    endtask

    logic [2:0]  st_f3   [0:4] = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001};
    logic [31:0] st_addr [0:4] = '{32'h1003, 32'h1002, 32'h1004, 32'h1000, 32'h1000};
    logic [31:0] st_rs2  [0:4] = '{32'hAABBCCDD, 32'h11223344, 32'hCAFEF00D, 32'h00000012, 32'h0000BEEF};
    logic [31:0] st_aadr [0:4] = '{32'h1000, 32'h1000, 32'h1004, 32'h1000, 32'h1000};
    logic [3:0]  st_strb [0:4] = '{4'b1000, 4'b1100, 4'b1111, 4'b0001, 4'b0011};
    logic [31:0] st_data [0:4] = '{32'hDDDDDDDD, 32'h33443344, 32'hCAFEF00D, 32'h12121212, 32'hBEEFBEEF};

    task automatic test_stores();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 1'b1, 1'b0, 1'b0, st_f3[i], st_addr[i], st_rs2[i], 5'd0);
            exp_q.push_back('{addr: st_aadr[i], we: 1'b1, wstrb: st_strb[i], wdata: st_data[i], load_data: 32'd0, rd: 5'd0, wait_cycles: 2});
            do_access(0, 0, 32'd0, 1'b0);
            e = exp_q.pop_front();
            checks++; if (obs_addr !== e.addr) begin errors++; $display("FAIL store%0d_addr: got %h expected %h", i, obs_addr, e.addr); end
            checks++; if (obs_we !== e.we) begin errors++; $display("FAIL store%0d_we: got %b expected %b", i, obs_we, e.we); end
            checks++; if (obs_wstrb !== e.wstrb) begin errors++; $display("FAIL store%0d_wstrb: got %b expected %b", i, obs_wstrb, e.wstrb); end
            checks++; if (obs_wdata !== e.wdata) begin errors++; $display("FAIL store%0d_wdata: got %h expected %h", i, obs_wdata, e.wdata); end
            checks++; if (obs_wait !== e.wait_cycles) begin errors++; $display("FAIL store%0d_wait_cycles: got %0d expected %0d", i, obs_wait, e.wait_cycles); end
            checks++; if (obs_req_cnt !== 1 || obs_timeout !== 1'b0) begin errors++; $display("FAIL store%0d_req_count: got %0d (timeout %b) expected 1", i, obs_req_cnt, obs_timeout); end
            checks++; if (obs_wb_rw !== 1'b0) begin errors++; $display("FAIL store%0d_wb_regwrite: got %b expected 0", i, obs_wb_rw); end
            issue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        end
    endtask

    logic [2:0]  ld_f3   [0:6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010, 3'b101};
    logic [31:0] ld_addr [0:6] = '{32'h2002, 32'h2002, 32'h2002, 32'h2002, 32'h2001, 32'h2008, 32'h2000};
    logic [31:0] ld_raw  [0:6] = '{32'h00800000, 32'h00800000, 32'h80010000, 32'h80010000, 32'h00007F00, 32'h12345678, 32'h0000FFFE};
    logic [31:0] ld_exp  [0:6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h0000007F, 32'h12345678, 32'h0000FFFE};
    int          ld_rdy  [0:6] = '{0, 0, 0, 1, 0, 2, 0};
    int          ld_rv   [0:6] = '{3, 3, 1, 1, 1, 1, 2};

    task automatic test_loads();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            issue(1'b1, 1'b0, 1'b1, 1'b1, ld_f3[i], ld_addr[i], 32'hFFFFFFFF, 5'(i + 1));
            exp_q.push_back('{addr: {ld_addr[i][31:2], 2'b00}, we: 1'b0, wstrb: 4'b0000, wdata: 32'd0,
                              load_data: ld_exp[i], rd: 5'(i + 1), wait_cycles: 2 + ld_rdy[i] + ld_rv[i]});
            do_access(ld_rdy[i], ld_rv[i], ld_raw[i], 1'b0);
            e = exp_q.pop_front();
            checks++; if (obs_addr !== e.addr || obs_we !== e.we || obs_wstrb !== e.wstrb) begin errors++; $display("FAIL load%0d_request: got addr %h we %b strb %b expected %h %b %b", i, obs_addr, obs_we, obs_wstrb, e.addr, e.we, e.wstrb); end
            checks++; if (obs_wb_load !== e.load_data) begin errors++; $display("FAIL load%0d_data: got %h expected %h", i, obs_wb_load, e.load_data); end
            checks++; if (obs_wb_rw !== 1'b1 || obs_wb_m2r !== 1'b1 || obs_wb_rd !== e.rd) begin errors++; $display("FAIL load%0d_wb_ctrl: got rw %b m2r %b rd %0d expected 1 1 %0d", i, obs_wb_rw, obs_wb_m2r, obs_wb_rd, e.rd); end
            checks++; if (obs_wb_alu !== ld_addr[i]) begin errors++; $display("FAIL load%0d_wb_alu: got %h expected %h", i, obs_wb_alu, ld_addr[i]); end
            checks++; if (obs_wait !== e.wait_cycles) begin errors++; $display("FAIL load%0d_wait_cycles: got %0d expected %0d", i, obs_wait, e.wait_cycles); end
            checks++; if (obs_req_cnt !== 1 || obs_timeout !== 1'b0) begin errors++; $display("FAIL load%0d_req_count: got %0d (timeout %b) expected 1", i, obs_req_cnt, obs_timeout); end
            issue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        end
    endtask

    task automatic test_load_stall();
        exp_t e;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h2010, 32'd0, 5'd20);
        exp_q.push_back('{addr: 32'h2010, we: 1'b0, wstrb: 4'b0000, wdata: 32'd0, load_data: 32'hA5A50F0F, rd: 5'd20, wait_cycles: 8});
        do_access(5, 1, 32'hA5A50F0F, 1'b1);
        e = exp_q.pop_front();
        checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL stall_req_stable: got %b expected 1", obs_stable); end
        checks++; if (obs_wait !== e.wait_cycles) begin errors++; $display("FAIL stall_wait_cycles: got %0d expected %0d", obs_wait, e.wait_cycles); end
        checks++; if (obs_bubble_ok !== 1'b1) begin errors++; $display("FAIL stall_wb_bubble: got %b expected 1", obs_bubble_ok); end
        checks++; if (obs_wb_load !== e.load_data || obs_wb_rd !== e.rd || obs_wb_rw !== 1'b1) begin errors++; $display("FAIL stall_wb: got ld %h rd %0d rw %b expected %h %0d 1", obs_wb_load, obs_wb_rd, obs_wb_rw, e.load_data, e.rd); end
        checks++; if (obs_req_cnt !== 1 || obs_addr !== e.addr) begin errors++; $display("FAIL stall_request: got cnt %0d addr %h expected 1 %h", obs_req_cnt, obs_addr, e.addr); end
        issue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    endtask

    logic        ma_mw   [0:4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  ma_f3   [0:4] = '{3'b001, 3'b010, 3'b010, 3'b001, 3'b010};
    logic [31:0] ma_addr [0:4] = '{32'h3001, 32'h3002, 32'h3001, 32'h3003, 32'h3002};

    task automatic test_misalign();
        for (int i = 0; i < 5; i++) begin
            issue(!ma_mw[i], ma_mw[i], 1'b1, !ma_mw[i], ma_f3[i], ma_addr[i], 32'h55AA55AA, 5'd9);
            @(negedge clk);
            checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign%0d_pulse: got %b expected 1", i, misalign); end
            checks++; if (D_req !== 1'b0 || D_core_wait !== 1'b0) begin errors++; $display("FAIL misalign%0d_no_req: got req %b wait %b expected 0 0", i, D_req, D_core_wait); end
            @(posedge clk); #1;
            checks++; if (MEM_WB_RegWrite !== 1'b0) begin errors++; $display("FAIL misalign%0d_regwrite: got %b expected 0", i, MEM_WB_RegWrite); end
            issue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
            @(negedge clk);
            checks++; if (misalign !== 1'b0 || D_req !== 1'b0) begin errors++; $display("FAIL misalign%0d_after: got misalign %b req %b expected 0 0", i, misalign, D_req); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_non_mem();
        issue(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h12345679, 32'd0, 5'd12);
        do_access(0, 0, 32'd0, 1'b0);
        checks++; if (obs_wait !== 0 || obs_req_cnt !== 0) begin errors++; $display("FAIL alu_no_stall: got wait %0d req %0d expected 0 0", obs_wait, obs_req_cnt); end
        checks++; if (obs_wb_rw !== 1'b1 || obs_wb_m2r !== 1'b0 || obs_wb_rd !== 5'd12 || obs_wb_alu !== 32'h12345679) begin errors++; $display("FAIL alu_wb: got rw %b m2r %b rd %0d alu %h expected 1 0 12 12345679", obs_wb_rw, obs_wb_m2r, obs_wb_rd, obs_wb_alu); end
        issue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h4000, 32'd0, 5'd7);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (D_req !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %b expected 1", D_req); end
        D_ready = 1'b1;
        @(posedge clk); #1;
        D_ready = 1'b0;
        @(negedge clk);
        checks++; if (D_req !== 1'b0 || D_core_wait !== 1'b1) begin errors++; $display("FAIL rstmid_resp: got req %b wait %b expected 0 1", D_req, D_core_wait); end
        rst = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        #1;
        checks++; if (D_req !== 1'b0 || D_core_wait !== 1'b0) begin errors++; $display("FAIL rstmid_async: got req %b wait %b expected 0 0", D_req, D_core_wait); end
        @(negedge clk);
        rst = 1'b0;
        D_rvalid = 1'b1; D_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        D_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (MEM_WB_RegWrite !== 1'b0 || D_req !== 1'b0 || D_core_wait !== 1'b0) begin errors++; $display("FAIL rstmid_late_rvalid%0d: got rw %b req %b wait %b expected 0 0 0", i, MEM_WB_RegWrite, D_req, D_core_wait); end
        end
        checks++; if (MEM_WB_load_data !== 32'd0) begin errors++; $display("FAIL rstmid_rdata_ignored: got %h expected 00000000", MEM_WB_load_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h5000, 32'h0BADF00D, 5'd0);
        exp_q.push_back('{addr: 32'h5000, we: 1'b1, wstrb: 4'b1111, wdata: 32'h0BADF00D, load_data: 32'd0, rd: 5'd0, wait_cycles: 2});
        do_access(0, 0, 32'd0, 1'b0);
        e = exp_q.pop_front();
        checks++; if (obs_req_cnt !== 1 || obs_addr !== e.addr || obs_wdata !== e.wdata || obs_wait !== e.wait_cycles) begin errors++; $display("FAIL b2b_store: got cnt %0d addr %h data %h wait %0d expected 1 %h %h %0d", obs_req_cnt, obs_addr, obs_wdata, obs_wait, e.addr, e.wdata, e.wait_cycles); end
        issue(1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 32'h5006, 32'd0, 5'd3);
        exp_q.push_back('{addr: 32'h5004, we: 1'b0, wstrb: 4'b0000, wdata: 32'd0, load_data: 32'h0000C0DE, rd: 5'd3, wait_cycles: 3});
        do_access(0, 1, 32'hC0DE1234, 1'b0);
        e = exp_q.pop_front();
        checks++; if (obs_req_cnt !== 1 || obs_addr !== e.addr || obs_we !== e.we || obs_wait !== e.wait_cycles) begin errors++; $display("FAIL b2b_load_req: got cnt %0d addr %h we %b wait %0d expected 1 %h %b %0d", obs_req_cnt, obs_addr, obs_we, obs_wait, e.addr, e.we, e.wait_cycles); end
        checks++; if (obs_wb_load !== e.load_data || obs_wb_rd !== e.rd) begin errors++; $display("FAIL b2b_load_data: got %h rd %0d expected %h %0d", obs_wb_load, obs_wb_rd, e.load_data, e.rd); end
        issue(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h5001, 32'h000000A7, 5'd0);
        exp_q.push_back('{addr: 32'h5000, we: 1'b1, wstrb: 4'b0010, wdata: 32'hA7A7A7A7, load_data: 32'd0, rd: 5'd0, wait_cycles: 2});
        do_access(0, 0, 32'd0, 1'b0);
        e = exp_q.pop_front();
        checks++; if (obs_req_cnt !== 1 || obs_wstrb !== e.wstrb || obs_wdata !== e.wdata) begin errors++; $display("FAIL b2b_sb: got cnt %0d strb %b data %h expected 1 %b %h", obs_req_cnt, obs_wstrb, obs_wdata, e.wstrb, e.wdata); end
        issue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (D_req !== 1'b0) begin errors++; $display("FAIL b2b_no_dup%0d: got %b expected 0", i, D_req); end
        end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_load_stall();
        test_misalign();
        test_non_mem();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
